// File: rtl/switch_allocator_if.sv
// Handshake bundle between the input buffers/route compute and the
// switch allocator: flit status and requests in, grants and selects out.
interface switch_allocator_if #(
  parameter int N_IN     = 12,
  parameter int N_OUT    = 12,
  parameter int SEL_BITS = 4
) ();
  logic [N_IN-1:0]           in_valid;
  logic [N_IN-1:0]           in_head;
  logic [N_IN-1:0]           in_tail;
  logic [N_IN*N_OUT-1:0]     in_req;
  logic [N_OUT-1:0]          link_up;
  logic [N_OUT-1:0]          credit_ret;
  logic [N_IN-1:0]           gnt;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT*SEL_BITS-1:0] out_sel;
  logic                      credit_err;
  logic [N_OUT-1:0]          wdog_flag;

  modport master (
    output in_valid, in_head, in_tail, in_req,
    output link_up, credit_ret,
    input  gnt, out_valid, out_sel,
    input  credit_err, wdog_flag
  );

  modport slave (
    input  in_valid, in_head, in_tail, in_req,
    input  link_up, credit_ret,
    output gnt, out_valid, out_sel,
    output credit_err, wdog_flag
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration,
// lock until tail, credit and link gating. Ports: clk, rst (sync,
// active-high), bus (switch_allocator_if.slave). Optional lock watchdog
// enabled by defining SWALLOC_WDOG_EN.
module switch_allocator #(
  parameter int N_IN        = 12,
  parameter int N_OUT       = 12,
  parameter int SEL_BITS    = 4,
  parameter int MAX_CREDITS = 4,
  parameter int CRED_BITS   = 3,
  parameter int WDOG_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  switch_allocator_if.slave bus
);

  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CRED_BITS-1:0] CMAX =
    CRED_BITS'(MAX_CREDITS);

  if ((1 << SEL_BITS) < N_IN) begin : g_chk_sel
    $error("SEL_BITS too small for N_IN");
  end
  if (MAX_CREDITS >= (1 << CRED_BITS)) begin : g_chk_cred
    $error("CRED_BITS too small for MAX_CREDITS");
  end
  if (WDOG_CYCLES < 1) begin : g_chk_wdog
    $error("WDOG_CYCLES must be positive");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } st_t;

  st_t                 st_q    [N_OUT];
  st_t                 st_d    [N_OUT];
  logic [SEL_BITS-1:0] owner_q [N_OUT];
  logic [SEL_BITS-1:0] owner_d [N_OUT];
  logic [SEL_BITS-1:0] rr_q    [N_OUT];
  logic [SEL_BITS-1:0] rr_d    [N_OUT];
  logic [CRED_BITS-1:0] cred_q [N_OUT];
  logic [CRED_BITS-1:0] cred_d [N_OUT];
  logic                err_q;
  logic                err_d;

  logic [OW-1:0]       lo_idx  [N_IN];
  logic [N_IN-1:0]     lo_any;
  logic [N_IN-1:0]     locked_in;
  logic [N_IN-1:0]     cand    [N_OUT];
  logic [N_OUT-1:0]    grant_o;
  logic [SEL_BITS-1:0] win     [N_OUT];

  logic [N_IN-1:0]           gnt_w;
  logic [N_OUT-1:0]          oval_w;
  logic [N_OUT*SEL_BITS-1:0] osel_w;

  function automatic logic [SEL_BITS-1:0] nxt(
    input logic [SEL_BITS-1:0] v
  );
    if (v == SEL_BITS'(N_IN - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Only the lowest requested output counts; scan high to low.
  always_comb begin
    lo_any = '0;
    for (int i = 0; i < N_IN; i++) begin
      lo_idx[i] = '0;
      for (int j = N_OUT - 1; j >= 0; j--) begin
        if (bus.in_req[i*N_OUT + j]) begin
          lo_any[i] = 1'b1;
          lo_idx[i] = OW'(j);
        end
      end
    end
  end

  // Inputs already holding an output cannot start a second packet.
  always_comb begin
    locked_in = '0;
    for (int o = 0; o < N_OUT; o++) begin
      if (st_q[o] == LOCKED) locked_in[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) begin
        cand[o][i] = bus.in_valid[i] & bus.in_head[i] &
                     lo_any[i] & ~locked_in[i] &
                     (lo_idx[i] == OW'(o));
      end
    end
  end

  always_comb begin
    logic                found;
    logic [SEL_BITS:0]   sum;
    logic [SEL_BITS-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int o = 0; o < N_OUT; o++) begin
      win[o] = '0;
      found  = 1'b0;
      if (st_q[o] == LOCKED) begin
        win[o]     = owner_q[o];
        grant_o[o] = bus.in_valid[owner_q[o]] &&
                     (cred_q[o] != '0);
      end else if (bus.link_up[o] && (cred_q[o] != '0)) begin
        for (int k = 0; k < N_IN; k++) begin
          sum = {1'b0, rr_q[o]} + (SEL_BITS+1)'(k);
          if (sum >= (SEL_BITS+1)'(N_IN))
            sum = sum - (SEL_BITS+1)'(N_IN);
          idx = sum[SEL_BITS-1:0];
          if (!found && cand[o][idx]) begin
            found  = 1'b1;
            win[o] = idx;
          end
        end
        grant_o[o] = found;
      end
      if (rst) grant_o[o] = 1'b0;
    end
  end

  always_comb begin
    gnt_w  = '0;
    oval_w = '0;
    osel_w = '0;
    for (int o = 0; o < N_OUT; o++) begin
      if (grant_o[o]) begin
        gnt_w[win[o]] = 1'b1;
        oval_w[o]     = 1'b1;
        osel_w[o*SEL_BITS +: SEL_BITS] = win[o];
      end
    end
  end

  assign bus.gnt        = gnt_w;
  assign bus.out_valid  = oval_w;
  assign bus.out_sel    = osel_w;
  assign bus.credit_err = err_q;

`ifdef SWALLOC_WDOG_EN
  localparam int WB = $clog2(WDOG_CYCLES + 1);
  logic [WB-1:0]    wcnt_q [N_OUT];
  logic [WB-1:0]    wcnt_d [N_OUT];
  logic [N_OUT-1:0] wflag_q;
  logic [N_OUT-1:0] wflag_d;
  assign bus.wdog_flag = wflag_q;
`else
  assign bus.wdog_flag = '0;
`endif

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cred_d  = cred_q;
    err_d   = err_q;
`ifdef SWALLOC_WDOG_EN
    wcnt_d  = wcnt_q;
    wflag_d = wflag_q;
`endif
    for (int o = 0; o < N_OUT; o++) begin
      if (grant_o[o]) begin
        if (st_q[o] == IDLE) begin
          if (!bus.in_tail[win[o]]) begin
            st_d[o]    = LOCKED;
            owner_d[o] = win[o];
          end else begin
            rr_d[o] = nxt(win[o]);
          end
        end else if (bus.in_tail[win[o]]) begin
          st_d[o] = IDLE;
          rr_d[o] = nxt(owner_q[o]);
        end
      end

      if (grant_o[o] && !bus.credit_ret[o]) begin
        cred_d[o] = cred_q[o] - 1'b1;
      end else if (!grant_o[o] && bus.credit_ret[o]) begin
        if (cred_q[o] == CMAX) err_d = 1'b1;
        else cred_d[o] = cred_q[o] + 1'b1;
      end

`ifdef SWALLOC_WDOG_EN
      // A stalled lock is broken so waiting heads are not starved.
      if ((st_q[o] == LOCKED) && !grant_o[o]) begin
        if (wcnt_q[o] == WB'(WDOG_CYCLES - 1)) begin
          st_d[o]    = IDLE;
          rr_d[o]    = nxt(owner_q[o]);
          wflag_d[o] = 1'b1;
          wcnt_d[o]  = '0;
        end else begin
          wcnt_d[o] = wcnt_q[o] + 1'b1;
        end
      end else begin
        wcnt_d[o] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N_OUT; o++) begin
        st_q[o]    <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cred_q[o]  <= CMAX;
`ifdef SWALLOC_WDOG_EN
        wcnt_q[o]  <= '0;
`endif
      end
      err_q <= 1'b0;
`ifdef SWALLOC_WDOG_EN
      wflag_q <= '0;
`endif
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
`ifdef SWALLOC_WDOG_EN
      wcnt_q  <= wcnt_d;
      wflag_q <= wflag_d;
`endif
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: arbitration, wormhole locking,
// credits, link gating, reset and (with SWALLOC_WDOG_EN) the watchdog.
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  switch_allocator_if #(.N_IN(12), .N_OUT(12), .SEL_BITS(4)) bus ();

  switch_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [3:0] sel(input int o);
    return bus.out_sel[o*4 +: 4];
  endfunction

  task automatic clr();
    bus.in_valid   = '0;
    bus.in_head    = '0;
    bus.in_tail    = '0;
    bus.in_req     = '0;
    bus.link_up    = '1;
    bus.credit_ret = '0;
  endtask

  task automatic flit(input int i, input bit h, input bit t,
                      input int o);
    logic [11:0] one;
    one = 12'd1;
    bus.in_valid[i] = 1'b1;
    bus.in_head[i]  = h;
    bus.in_tail[i]  = t;
    bus.in_req[i*12 +: 12] = one << o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr();
    rst = 1'b1;
    flit(0, 1, 1, 2);
    #1;
    checks++;
    if (bus.gnt !== 12'h000 || bus.out_valid !== 12'h000 ||
        bus.out_sel !== '0) begin
      errors++;
      $display("FAIL rst_outs gnt=%h ov=%h sel=%h want 0",
               bus.gnt, bus.out_valid, bus.out_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    clr();
    #1;
    checks++;
    if (bus.credit_err !== 1'b0 || bus.wdog_flag !== 12'h000) begin
      errors++;
      $display("FAIL rst_flags err=%b wdog=%h want 0 0",
               bus.credit_err, bus.wdog_flag);
    end
    @(negedge clk);
    clr();
    flit(0, 1, 1, 2);
    flit(3, 1, 1, 2);
    #1;
    checks++;
    if (bus.gnt !== 12'h001 || sel(2) !== 4'd0) begin
      errors++;
      $display("FAIL rr_first gnt=%h sel=%0d want 001 0",
               bus.gnt, sel(2));
    end
    @(negedge clk);
    clr();
    flit(3, 1, 1, 2);
    #1;
    checks++;
    if (bus.gnt !== 12'h008 || sel(2) !== 4'd3 ||
        bus.out_valid !== 12'h004) begin
      errors++;
      $display("FAIL rr_second gnt=%h sel=%0d ov=%h want 008 3 004",
               bus.gnt, sel(2), bus.out_valid);
    end
    // two credits remain on output 2
    for (int c = 0; c < 3; c++) begin
      logic [11:0] exp;
      @(negedge clk);
      clr();
      flit(3, 1, 1, 2);
      #1;
      exp = (c < 2) ? 12'h008 : 12'h000;
      checks++;
      if (bus.gnt !== exp) begin
        errors++;
        $display("FAIL cred_left c=%0d gnt=%h want %h",
                 c, bus.gnt, exp);
      end
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic [11:0] exp;
      logic [3:0]  exs;
      @(negedge clk);
      clr();
      if (c < 4) flit(5, c == 0, c == 3, 8);
      if (c >= 1) begin
        flit(1, 1, 1, 8);
        bus.credit_ret[8] = 1'b1;
      end
      #1;
      exp = (c < 4) ? 12'h020 : 12'h002;
      exs = (c < 4) ? 4'd5 : 4'd1;
      checks++;
      if (bus.gnt !== exp || sel(8) !== exs ||
          bus.out_valid !== 12'h100) begin
        errors++;
        $display("FAIL wormhole c=%0d gnt=%h sel=%0d ov=%h want %h %0d 100",
                 c, bus.gnt, sel(8), bus.out_valid, exp, exs);
      end
    end
  endtask

  task automatic test_credit();
    int fi;
    fi = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      logic eg;
      @(negedge clk);
      clr();
      flit(2, fi == 0, fi == 5, 0);
      bus.credit_ret[0] = (c >= 6);
      #1;
      eg = (c < 4) || (c == 7) || (c == 8);
      checks++;
      if (bus.gnt[2] !== eg) begin
        errors++;
        $display("FAIL credit c=%0d gnt=%b want %b", c, bus.gnt[2], eg);
      end
      if (eg) fi++;
    end
    for (int c = 9; c < 13; c++) begin
      @(negedge clk);
      clr();
      bus.credit_ret[0] = 1'b1;
    end
    #1;
    checks++;
    if (bus.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL cred_err_early got %b want 0", bus.credit_err);
    end
    @(negedge clk);
    clr();
    #1;
    checks++;
    if (bus.credit_err !== 1'b1) begin
      errors++;
      $display("FAIL cred_err_set got %b want 1", bus.credit_err);
    end
  endtask

  task automatic test_link();
    logic [11:0] exp [5];
    exp = '{12'h000, 12'h010, 12'h010, 12'h010, 12'h000};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr();
      bus.link_up[3] = (c == 1);
      case (c)
        0, 1:    flit(4, 1, 0, 3);
        2:       flit(4, 0, 0, 3);
        3:       flit(4, 0, 1, 3);
        default: flit(6, 1, 1, 3);
      endcase
      #1;
      checks++;
      if (bus.gnt !== exp[c]) begin
        errors++;
        $display("FAIL link c=%0d gnt=%h want %h", c, bus.gnt, exp[c]);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      clr();
      flit(7, c == 0, 0, 1);
      #1;
      checks++;
      if (bus.gnt !== 12'h080) begin
        errors++;
        $display("FAIL mid_pre c=%0d gnt=%h want 080", c, bus.gnt);
      end
    end
    @(negedge clk);
    clr();
    rst = 1'b1;
    flit(7, 0, 0, 1);
    #1;
    checks++;
    if (bus.gnt !== 12'h000 || bus.out_valid !== 12'h000) begin
      errors++;
      $display("FAIL mid_rst gnt=%h ov=%h want 0 0",
               bus.gnt, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    clr();
    flit(7, 0, 0, 1);
    flit(9, 1, 1, 1);
    #1;
    checks++;
    if (bus.gnt !== 12'h200 || sel(1) !== 4'd9) begin
      errors++;
      $display("FAIL mid_after gnt=%h sel=%0d want 200 9",
               bus.gnt, sel(1));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      logic [11:0] exp;
      @(negedge clk);
      clr();
      if (c < 2) flit(10, c == 0, c == 1, 5);
      else       flit(11, 1, 1, 5);
      #1;
      exp = (c < 2) ? 12'h400 : 12'h800;
      checks++;
      if (bus.gnt !== exp) begin
        errors++;
        $display("FAIL b2b c=%0d gnt=%h want %h", c, bus.gnt, exp);
      end
    end
    checks++;
    if (sel(5) !== 4'd11) begin
      errors++;
      $display("FAIL b2b_sel got %0d want 11", sel(5));
    end
    @(negedge clk);
    clr();
    flit(0, 1, 1, 4);
    flit(1, 1, 1, 6);
    #1;
    checks++;
    if (bus.gnt !== 12'h003 || bus.out_valid !== 12'h050) begin
      errors++;
      $display("FAIL parallel gnt=%h ov=%h want 003 050",
               bus.gnt, bus.out_valid);
    end
    @(negedge clk);
    clr();
    flit(2, 1, 1, 9);
    bus.in_req[2*12 +: 12] = 12'h280;
    #1;
    checks++;
    if (bus.gnt !== 12'h004 || bus.out_valid !== 12'h080) begin
      errors++;
      $display("FAIL multihot gnt=%h ov=%h want 004 080",
               bus.gnt, bus.out_valid);
    end
    @(negedge clk);
    clr();
    flit(3, 1, 1, 0);
    bus.in_req[3*12 +: 12] = 12'h000;
    flit(4, 0, 0, 1);
    #1;
    checks++;
    if (bus.gnt !== 12'h000 || bus.out_valid !== 12'h000) begin
      errors++;
      $display("FAIL noreq_body gnt=%h ov=%h want 0 0",
               bus.gnt, bus.out_valid);
    end
  endtask

`ifdef SWALLOC_WDOG_EN
  task automatic test_wdog();
    int bad;
    bad = 0;
    do_reset();
    @(negedge clk);
    clr();
    flit(0, 1, 0, 2);
    #1;
    checks++;
    if (bus.gnt !== 12'h001) begin
      errors++;
      $display("FAIL wdog_head gnt=%h want 001", bus.gnt);
    end
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      clr();
      flit(1, 1, 1, 2);
      #1;
      if (bus.gnt !== 12'h000 || bus.wdog_flag !== 12'h000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdog_stall bad_cycles=%0d want 0", bad);
    end
    @(negedge clk);
    clr();
    flit(1, 1, 1, 2);
    #1;
    checks++;
    if (bus.gnt !== 12'h002 || bus.wdog_flag !== 12'h004) begin
      errors++;
      $display("FAIL wdog_fire gnt=%h flag=%h want 002 004",
               bus.gnt, bus.wdog_flag);
    end
  endtask
`endif

  initial begin
    clr();
    test_reset();
    test_wormhole();
    test_credit();
    test_link();
    test_rst_mid();
    test_back_to_back();
`ifdef SWALLOC_WDOG_EN
    test_wdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
